// File: rtl/bp_pkg.sv
// Shared types and counter helpers for the IF-stage branch prediction unit.
package bp_pkg;

  // Control-flow class stored with each BTB entry.
  typedef enum logic [1:0] {
    BP_BRANCH = 2'd0,
    BP_JUMP   = 2'd1,
    BP_CALL   = 2'd2,
    BP_RET    = 2'd3
  } bp_type_e;

  // Counters are stored at the widest supported width; only the low
  // CTR_BITS are ever non-zero, so one entry type serves every configuration.
  localparam int unsigned CTR_MAX_BITS = 3;

  // Per-entry metadata; tag and target live in separate arrays.
  typedef struct packed {
    logic                    valid;
    bp_type_e                btype;
    logic [CTR_MAX_BITS-1:0] ctr;
  } btb_entry_t;

  // Weakly-taken starting value for a freshly allocated branch.
  function automatic logic [CTR_MAX_BITS-1:0] ctr_init(input int unsigned bits);
    return CTR_MAX_BITS'(1 << (bits - 1));
  endfunction

  // Saturating step in the resolved direction; never wraps at either end.
  function automatic logic [CTR_MAX_BITS-1:0] ctr_next(input logic [CTR_MAX_BITS-1:0] ctr,
                                                       input logic                    taken,
                                                       input int unsigned             bits);
    logic [CTR_MAX_BITS-1:0] sat;
    sat = CTR_MAX_BITS'((1 << bits) - 1);
    if (taken) begin
      return (ctr == sat) ? ctr : ctr + CTR_MAX_BITS'(1);
    end
    return (ctr == '0) ? ctr : ctr - CTR_MAX_BITS'(1);
  endfunction

endpackage

// File: rtl/return_address_stack.sv
// Speculative circular return address stack. A push when full overwrites the
// oldest entry; a pop when empty is ignored. Clear empties the stack.
module return_address_stack #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic            i_clear,
  input  logic [XLEN-1:0] i_push_addr,
  output logic [XLEN-1:0] o_top,
  output logic            o_empty
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0]  stack_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // ptr_q is the next slot to write; the top is the slot just below it.
  assign o_top   = stack_q[ptr_q - PTR_W'(1)];
  assign o_empty = (cnt_q == '0);

  // Next pointer/count: clear beats push, push beats pop.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_push) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (cnt_q != CNT_W'(RAS_DEPTH)) cnt_d = cnt_q + CNT_W'(1);
    end else if (i_pop && !o_empty) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Stack storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && !i_clear && i_push) stack_q[ptr_q] <= i_push_addr;
  end

endmodule

// File: rtl/branch_prediction_unit.sv
// IF-stage prediction: direct-mapped BTB with saturating direction counters,
// RAS-backed return prediction, combinational redirect and registered
// metadata for the instruction arriving one cycle later.
module branch_prediction_unit
  import bp_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BTB_ENTRIES = 32,
  parameter int unsigned CTR_BITS    = 2,
  parameter int unsigned RAS_DEPTH   = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_stall,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_block_prediction,
  input  logic            i_disable_branch_prediction,
  input  logic            i_upd_valid,
  input  logic [XLEN-1:0] i_upd_pc,
  input  logic [XLEN-1:0] i_upd_target,
  input  logic            i_upd_taken,
  input  logic [1:0]      i_upd_type,
  output logic            o_predicted_taken,
  output logic [XLEN-1:0] o_predicted_target,
  output logic            o_prediction_used,
  output logic            o_control_flow_to_halfword_pred,
  output logic            o_prediction_used_r,
  output logic [XLEN-1:0] o_predicted_target_r,
  output logic [1:0]      o_predicted_type_r,
  output logic            o_prediction_holdoff
);

  localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = XLEN - 2 - IDX_W;

  btb_entry_t       meta_q    [BTB_ENTRIES];
  logic [TAG_W-1:0] btb_tag_q [BTB_ENTRIES];
  logic [XLEN-1:0]  btb_tgt_q [BTB_ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  btb_entry_t       lk_entry;
  logic             lk_hit;
  logic             lk_taken;
  bp_type_e         lk_type;
  logic [XLEN-1:0]  lk_target;
  logic             sel_prediction;

  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  btb_entry_t       upd_entry;
  bp_type_e         upd_type;
  logic             upd_hit;
  logic             upd_is_br;
  logic             upd_alloc;
  logic             upd_tgt_we;

  logic             ras_push;
  logic             ras_pop;
  logic [XLEN-1:0]  ras_top;
  logic             ras_empty;

  logic             used_r_q, used_r_d;
  logic             holdoff_q, holdoff_d;
  logic [XLEN-1:0]  tgt_r_q, tgt_r_d;
  bp_type_e         type_r_q, type_r_d;

  // Halfword offset of the fetch PC is handled by the pc[1] gate; byte
  // offsets of resolved PCs never select an entry.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{i_pc[0], i_upd_pc[1:0]};

  assign lk_idx  = i_pc[2 +: IDX_W];
  assign lk_tag  = i_pc[XLEN-1 : 2+IDX_W];
  assign upd_idx = i_upd_pc[2 +: IDX_W];
  assign upd_tag = i_upd_pc[XLEN-1 : 2+IDX_W];
  assign upd_type = bp_type_e'(i_upd_type);

  // Lookup reads pre-update contents; an update in this cycle shows next cycle.
  always_comb begin
    lk_entry  = meta_q[lk_idx];
    lk_hit    = lk_entry.valid && (btb_tag_q[lk_idx] == lk_tag);
    lk_taken  = lk_hit && ((lk_entry.btype != BP_BRANCH) || lk_entry.ctr[CTR_BITS-1]);
    lk_type   = lk_hit ? lk_entry.btype : BP_BRANCH;
    lk_target = '0;
    if (lk_hit) begin
      if ((lk_entry.btype == BP_RET) && !ras_empty) lk_target = ras_top;
      else                                          lk_target = btb_tgt_q[lk_idx];
    end
    sel_prediction = i_rst_n && !i_stall && !i_block_prediction && lk_taken
                     && !i_pc[1] && !i_disable_branch_prediction;
  end

  assign o_predicted_taken               = lk_taken;
  assign o_predicted_target              = lk_target;
  assign o_prediction_used               = sel_prediction;
  assign o_control_flow_to_halfword_pred = sel_prediction && lk_target[1];

  // Speculative call/return tracking; a flush empties the stack and wins.
  assign ras_push = sel_prediction && !i_flush && (lk_type == BP_CALL);
  assign ras_pop  = sel_prediction && !i_flush && (lk_type == BP_RET);

  return_address_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (ras_push),
    .i_pop       (ras_pop),
    .i_clear     (i_flush),
    .i_push_addr (i_pc + XLEN'(4)),
    .o_top       (ras_top),
    .o_empty     (ras_empty)
  );

  // Update-side hit detection and write enables for tag/target arrays.
  always_comb begin
    upd_entry  = meta_q[upd_idx];
    upd_hit    = upd_entry.valid && (btb_tag_q[upd_idx] == upd_tag);
    upd_is_br  = (upd_entry.btype == BP_BRANCH);
    upd_alloc  = i_upd_valid && !upd_hit && i_upd_taken;
    upd_tgt_we = i_upd_valid && (upd_hit ? (!upd_is_br || i_upd_taken) : i_upd_taken);
  end

  // Entry metadata: valid/type/counter; updates ignore stall.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < BTB_ENTRIES; i++) meta_q[i] <= '0;
    end else if (i_upd_valid) begin
      if (upd_hit) begin
        if (upd_is_br) meta_q[upd_idx].ctr   <= ctr_next(upd_entry.ctr, i_upd_taken, CTR_BITS);
        else           meta_q[upd_idx].btype <= upd_type;
      end else if (i_upd_taken) begin
        meta_q[upd_idx].valid <= 1'b1;
        meta_q[upd_idx].btype <= upd_type;
        meta_q[upd_idx].ctr   <= ctr_init(CTR_BITS);
      end
    end
  end

  // Tag and target storage; only qualified by the valid bits above.
  always_ff @(posedge i_clk) begin
    if (upd_alloc)  btb_tag_q[upd_idx] <= upd_tag;
    if (upd_tgt_we) btb_tgt_q[upd_idx] <= i_upd_target;
  end

  // Next values for the metadata handed to the following instruction.
  always_comb begin
    used_r_d  = used_r_q;
    holdoff_d = holdoff_q;
    tgt_r_d   = tgt_r_q;
    type_r_d  = type_r_q;
    if (!i_stall) begin
      used_r_d  = sel_prediction && !i_flush;
      holdoff_d = sel_prediction && !i_flush;
      tgt_r_d   = lk_target;
      type_r_d  = lk_type;
    end
  end

  // Registered prediction metadata and holdoff.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      used_r_q  <= 1'b0;
      holdoff_q <= 1'b0;
      tgt_r_q   <= '0;
      type_r_q  <= BP_BRANCH;
    end else begin
      used_r_q  <= used_r_d;
      holdoff_q <= holdoff_d;
      tgt_r_q   <= tgt_r_d;
      type_r_q  <= type_r_d;
    end
  end

  assign o_prediction_used_r  = used_r_q;
  assign o_prediction_holdoff = holdoff_q;
  assign o_predicted_target_r = tgt_r_q;
  assign o_predicted_type_r   = type_r_q;

endmodule

// File: tb/tb_branch_prediction_unit.sv
// Directed bench for branch_prediction_unit with hand-computed expectations.
module tb_branch_prediction_unit;

  localparam logic [31:0] PARK = 32'h0000_1000;
  localparam logic [1:0]  T_BR = 2'd0, T_JMP = 2'd1, T_CALL = 2'd2, T_RET = 2'd3;

  logic        i_clk = 1'b0;
  logic        i_rst_n, i_stall, i_flush, i_block_prediction, i_disable_branch_prediction;
  logic [31:0] i_pc, i_upd_pc, i_upd_target;
  logic        i_upd_valid, i_upd_taken;
  logic [1:0]  i_upd_type;
  logic        o_predicted_taken, o_prediction_used, o_control_flow_to_halfword_pred;
  logic        o_prediction_used_r, o_prediction_holdoff;
  logic [31:0] o_predicted_target, o_predicted_target_r;
  logic [1:0]  o_predicted_type_r;

  int n_checks = 0;
  int n_pass   = 0;

  branch_prediction_unit dut (
    .i_clk                           (i_clk),
    .i_rst_n                         (i_rst_n),
    .i_stall                         (i_stall),
    .i_flush                         (i_flush),
    .i_pc                            (i_pc),
    .i_block_prediction              (i_block_prediction),
    .i_disable_branch_prediction     (i_disable_branch_prediction),
    .i_upd_valid                     (i_upd_valid),
    .i_upd_pc                        (i_upd_pc),
    .i_upd_target                    (i_upd_target),
    .i_upd_taken                     (i_upd_taken),
    .i_upd_type                      (i_upd_type),
    .o_predicted_taken               (o_predicted_taken),
    .o_predicted_target              (o_predicted_target),
    .o_prediction_used               (o_prediction_used),
    .o_control_flow_to_halfword_pred (o_control_flow_to_halfword_pred),
    .o_prediction_used_r             (o_prediction_used_r),
    .o_predicted_target_r            (o_predicted_target_r),
    .o_predicted_type_r              (o_predicted_type_r),
    .o_prediction_holdoff            (o_prediction_holdoff)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic lookup(input logic [31:0] pc);
    i_pc = pc;
    #1;
  endtask

  task automatic btb_upd(input logic [31:0] pc, input logic [31:0] tgt,
                         input logic tk, input logic [1:0] ty);
    i_pc         = PARK;
    i_upd_valid  = 1'b1;
    i_upd_pc     = pc;
    i_upd_target = tgt;
    i_upd_taken  = tk;
    i_upd_type   = ty;
    tick();
    i_upd_valid  = 1'b0;
  endtask

  logic [31:0] call_pc [5] = '{32'h300, 32'h310, 32'h320, 32'h330, 32'h350};
  logic [31:0] pop_exp [5] = '{32'h354, 32'h334, 32'h324, 32'h314, 32'hF00};

  initial begin
    i_rst_n = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
    i_block_prediction = 1'b0; i_disable_branch_prediction = 1'b0;
    i_pc = PARK; i_upd_valid = 1'b0; i_upd_pc = '0; i_upd_target = '0;
    i_upd_taken = 1'b0; i_upd_type = T_BR;
    tick(); tick();
    i_rst_n = 1'b1;

    // Reset state
    lookup(32'h100);
    check("rst_taken",    o_predicted_taken,    0);
    check("rst_used",     o_prediction_used,    0);
    check("rst_used_r",   o_prediction_used_r,  0);
    check("rst_target_r", o_predicted_target_r, 0);
    check("rst_type_r",   o_predicted_type_r,   0);
    check("rst_holdoff",  o_prediction_holdoff, 0);

    // Allocate taken branch, predict, then registered metadata and holdoff
    btb_upd(32'h100, 32'h200, 1'b1, T_BR);
    lookup(32'h100);
    check("br_taken",  o_predicted_taken,  1);
    check("br_used",   o_prediction_used,  1);
    check("br_target", o_predicted_target, 32'h200);
    check("br_hw",     o_control_flow_to_halfword_pred, 0);
    tick();
    check("br_used_r",   o_prediction_used_r,  1);
    check("br_holdoff",  o_prediction_holdoff, 1);
    check("br_target_r", o_predicted_target_r, 32'h200);
    lookup(PARK);
    tick();
    check("holdoff_one_cycle", o_prediction_holdoff, 0);
    check("used_r_clears",     o_prediction_used_r,  0);

    // Counter 2 -> 1 -> 0 -> 0, then back up 1 -> 2
    btb_upd(32'h100, 32'h200, 1'b0, T_BR);
    lookup(32'h100);
    check("ctr1_not_taken", o_predicted_taken, 0);
    btb_upd(32'h100, 32'h200, 1'b0, T_BR);
    btb_upd(32'h100, 32'h200, 1'b0, T_BR);
    btb_upd(32'h100, 32'h204, 1'b1, T_BR);
    lookup(32'h100);
    check("ctr_no_wrap", o_predicted_taken, 0);
    btb_upd(32'h100, 32'h204, 1'b1, T_BR);
    lookup(32'h100);
    check("ctr2_taken",      o_predicted_taken,  1);
    check("br_target_rewr",  o_predicted_target, 32'h204);

    // CALL then RET through the RAS
    btb_upd(32'h300, 32'h800, 1'b1, T_CALL);
    btb_upd(32'h840, 32'hF00, 1'b1, T_RET);
    lookup(32'h300);
    check("call_used",   o_prediction_used,  1);
    check("call_target", o_predicted_target, 32'h800);
    tick();
    lookup(32'h840);
    check("ret_ras_target", o_predicted_target, 32'h304);
    check("ret_used",       o_prediction_used,  1);
    tick();
    check("ret_target_r",  o_predicted_target_r, 32'h304);
    check("ret_type_r",    o_predicted_type_r,   T_RET);
    check("ras_empty_btb", o_predicted_target,   32'hF00);

    // Five pushes into a four-deep stack: oldest overwritten
    btb_upd(32'h310, 32'h800, 1'b1, T_CALL);
    btb_upd(32'h320, 32'h800, 1'b1, T_CALL);
    btb_upd(32'h330, 32'h800, 1'b1, T_CALL);
    btb_upd(32'h350, 32'h800, 1'b1, T_CALL);
    for (int k = 0; k < 5; k++) begin
      lookup(call_pc[k]);
      check($sformatf("push%0d_used", k), o_prediction_used, 1);
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      lookup(32'h840);
      check($sformatf("pop%0d_target", k), o_predicted_target, pop_exp[k]);
      tick();
    end

    // Halfword-aligned fetch, disable and block gating
    lookup(32'h312);
    check("pc1_taken", o_predicted_taken, 1);
    check("pc1_used",  o_prediction_used, 0);
    i_disable_branch_prediction = 1'b1;
    lookup(32'h300);
    check("disable_used", o_prediction_used, 0);
    i_disable_branch_prediction = 1'b0;
    i_block_prediction = 1'b1;
    lookup(32'h300);
    check("block_used", o_prediction_used, 0);
    i_block_prediction = 1'b0;

    // Stall holds registered outputs
    lookup(32'h840);
    tick();
    i_stall = 1'b1;
    lookup(32'h300);
    check("stall_used", o_prediction_used, 0);
    tick();
    check("stall_used_r",   o_prediction_used_r,  1);
    check("stall_target_r", o_predicted_target_r, 32'hF00);
    check("stall_type_r",   o_predicted_type_r,   T_RET);
    check("stall_holdoff",  o_prediction_holdoff, 1);
    i_stall = 1'b0;

    // Flush during a used prediction empties the RAS
    lookup(32'h300);
    tick();
    i_flush = 1'b1;
    lookup(32'h310);
    check("flush_used", o_prediction_used, 1);
    tick();
    i_flush = 1'b0;
    check("flush_used_r",   o_prediction_used_r,  0);
    check("flush_holdoff",  o_prediction_holdoff, 0);
    check("flush_target_r", o_predicted_target_r, 32'h800);
    check("flush_type_r",   o_predicted_type_r,   T_CALL);
    lookup(32'h840);
    check("flush_ras_empty", o_predicted_target, 32'hF00);

    // Target with bit 1 set flags a halfword redirect
    btb_upd(32'h360, 32'h402, 1'b1, T_JMP);
    lookup(32'h360);
    check("hw_used", o_prediction_used, 1);
    check("hw_pred", o_control_flow_to_halfword_pred, 1);

    // Same-cycle lookup and update: no bypass
    i_pc = 32'h370; i_upd_valid = 1'b1; i_upd_pc = 32'h370;
    i_upd_target = 32'h500; i_upd_taken = 1'b1; i_upd_type = T_JMP;
    #1;
    check("same_cycle_pre", o_predicted_taken, 0);
    tick();
    i_upd_valid = 1'b0;
    #1;
    check("same_cycle_post",   o_predicted_taken,  1);
    check("same_cycle_target", o_predicted_target, 32'h500);

    // Reset mid-operation discards everything
    lookup(32'h300);
    tick();
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    #1;
    check("rst2_used_r",   o_prediction_used_r,  0);
    check("rst2_target_r", o_predicted_target_r, 0);
    check("rst2_holdoff",  o_prediction_holdoff, 0);
    check("rst2_btb_clear", o_predicted_taken,   0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
